// File: rtl/go_pkg.sv
// Shared types for the Go board datapath: cell encoding, move word, board array
// and the move-entry controller states.
package go_pkg;

    localparam int BOARD_N = 9;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BLACK = 2'b01,
        WHITE = 2'b10
    } cell_t;

    typedef struct packed {
        logic [3:0] row;
        logic [3:0] col;
    } move_t;

    // Indexed board[row][col], two bits per intersection.
    typedef logic [BOARD_N-1:0][BOARD_N-1:0][1:0] board_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CHECK = 2'b01,
        ISSUE = 2'b10,
        WAIT  = 2'b11
    } state_t;

endpackage

// File: rtl/wrap_counter9.sv
// One cursor axis: steps up/down by one with wrap-around at both ends.
// Opposing steps in the same cycle cancel out.
module wrap_counter9 #(
    parameter int BOARD_N   = go_pkg::BOARD_N,
    parameter int RESET_POS = 4
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       inc_i,
    input  logic       dec_i,
    input  logic       en_i,
    output logic [3:0] value_o
);

    localparam logic [3:0] MAX_V = 4'(BOARD_N - 1);
    localparam logic [3:0] RST_V = 4'(RESET_POS);

    logic [3:0] value_q;
    logic [3:0] value_d;

    // Next position: explicit compare-and-wrap, inc+dec together is a no-op.
    always_comb begin
        value_d = value_q;
        if (en_i && inc_i && !dec_i) begin
            value_d = (value_q >= MAX_V) ? 4'd0 : value_q + 4'd1;
        end else if (en_i && dec_i && !inc_i) begin
            value_d = (value_q == 4'd0) ? MAX_V : value_q - 4'd1;
        end
    end

    // Position register, centred on reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            value_q <= RST_V;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/move_entry.sv
// Player move-entry controller feeding board_updater. Button edges move the
// cursor and request moves; a requested point is checked for emptiness, then
// issued with a one-cycle start pulse, and the turn passes once the updater
// reports completion (or the wait times out).
module move_entry #(
    parameter int BOARD_N        = 9,
    parameter int TIMEOUT_CYCLES = 65_000,
    parameter int RESET_POS      = 4
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           btn_up,
    input  logic           btn_down,
    input  logic           btn_left,
    input  logic           btn_right,
    input  logic           btn_confirm,
    input  logic           btn_pass,
    input  go_pkg::board_t board,
    input  logic           board_ready,
    output logic [7:0]     move_out,
    output logic           start_flag,
    output logic           turn,
    output logic [3:0]     cursor_row,
    output logic [3:0]     cursor_col,
    output logic           busy,
    output logic           illegal_pulse,
    output logic           pass_pulse,
    output logic           timeout_pulse
);

    import go_pkg::*;

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Button vector order: {pass, confirm, right, left, down, up}
    logic [5:0] btn_now;
    logic [5:0] btn_q;
    logic [5:0] btn_edge;
    logic       ready_q;
    logic       ready_edge;

    state_t     state_q, state_d;
    move_t      move_q, move_d;
    logic [7:0] move_out_q, move_out_d;
    logic       start_q, start_d;
    logic       turn_q, turn_d;
    logic       illegal_q, illegal_d;
    logic       pass_q, pass_d;
    logic       timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       in_idle;
    logic       cell_empty;
    logic       timeout_hit;

    assign btn_now    = {btn_pass, btn_confirm, btn_right, btn_left, btn_down, btn_up};
    assign btn_edge   = btn_now & ~btn_q;
    assign ready_edge = board_ready & ~ready_q;

    assign in_idle     = (state_q == IDLE);
    assign cell_empty  = (board[move_q.row][move_q.col] == EMPTY);
    assign timeout_hit = (cnt_q == CNT_LAST);

    // Previous-level registers; loading the live level during reset means a
    // button (or board_ready) held through reset never looks like an edge.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            btn_q   <= btn_now;
            ready_q <= board_ready;
        end else begin
            btn_q   <= btn_now;
            ready_q <= board_ready;
        end
    end

    wrap_counter9 #(
        .BOARD_N   (BOARD_N),
        .RESET_POS (RESET_POS)
    ) u_row (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .inc_i   (btn_edge[1]),
        .dec_i   (btn_edge[0]),
        .en_i    (in_idle),
        .value_o (cursor_row)
    );

    wrap_counter9 #(
        .BOARD_N   (BOARD_N),
        .RESET_POS (RESET_POS)
    ) u_col (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .inc_i   (btn_edge[3]),
        .dec_i   (btn_edge[2]),
        .en_i    (in_idle),
        .value_o (cursor_col)
    );

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a board_ready edge takes priority over the timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (btn_edge[4]) state_d = CHECK;
            CHECK:   state_d = cell_empty ? ISSUE : IDLE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (ready_edge || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values; pulses default low so they last one cycle.
    always_comb begin
        move_d     = move_q;
        move_out_d = move_out_q;
        start_d    = 1'b0;
        turn_d     = turn_q;
        illegal_d  = 1'b0;
        pass_d     = 1'b0;
        timeout_d  = 1'b0;
        cnt_d      = cnt_q;
        unique case (state_q)
            IDLE: begin
                // Latches the cursor as it stands this cycle, before any
                // simultaneous cursor edge takes effect.
                if (btn_edge[4]) begin
                    move_d = '{row: cursor_row, col: cursor_col};
                end else if (btn_edge[5]) begin
                    turn_d = ~turn_q;
                    pass_d = 1'b1;
                end
            end
            CHECK: begin
                // Registered here so move_out and start_flag appear together
                // during ISSUE.
                if (cell_empty) begin
                    move_out_d = move_q;
                    start_d    = 1'b1;
                end else begin
                    illegal_d = 1'b1;
                end
            end
            ISSUE: begin
                cnt_d = '0;
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_ONE;
                if (ready_edge) begin
                    turn_d = ~turn_q;
                end else if (timeout_hit) begin
                    timeout_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and control state.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            move_out_q <= '0;
            start_q    <= 1'b0;
            turn_q     <= 1'b1;
            illegal_q  <= 1'b0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            move_out_q <= move_out_d;
            start_q    <= start_d;
            turn_q     <= turn_d;
            illegal_q  <= illegal_d;
            pass_q     <= pass_d;
            timeout_q  <= timeout_d;
        end
    end

    // Latched move and wait counter are pure data; they are always written
    // before being read, so they carry no reset.
    always_ff @(posedge clk_in) begin
        move_q <= move_d;
        cnt_q  <= cnt_d;
    end

    assign move_out      = move_out_q;
    assign start_flag    = start_q;
    assign turn          = turn_q;
    assign busy          = (state_q != IDLE);
    assign illegal_pulse = illegal_q;
    assign pass_pulse    = pass_q;
    assign timeout_pulse = timeout_q;

endmodule

// File: doc/move_entry.md
Name: move_entry

Overview:
- Player move-entry controller that sits directly upstream of board_updater.
- Turns debounced button levels into a 9x9 cursor position.
- Checks that the target intersection is empty on the current board.
- Issues the 8-bit move and a one-cycle start pulse, then waits for the updater's board_ready before handing the turn over.
- Its cursor outputs also feed the display overlay.

Parameters:
- BOARD_N, 9, board side length; legal indices are 0..BOARD_N-1.
- TIMEOUT_CYCLES, 65_000, maximum WAIT cycles for board_ready (1 ms at 65 MHz).
- RESET_POS, 4, cursor row and column after reset (board centre).

Ports:
- clk_in  input  1  65 MHz system clock.
- rst_in  input  1  synchronous, active-high reset.
- btn_up  input  1  debounced level; cursor row - 1.
- btn_down  input  1  debounced level; cursor row + 1.
- btn_left  input  1  debounced level; cursor col - 1.
- btn_right  input  1  debounced level; cursor col + 1.
- btn_confirm  input  1  debounced level; place a stone at the cursor.
- btn_pass  input  1  debounced level; pass the turn.
- board  input  2x[9][9]  current board, indexed board[row][col]; 00 empty, 01 black, 10 white.
- board_ready  input  1  board_updater completion.
- move_out  output  8  {row[3:0], col[3:0]}, feeds board_updater move_in.
- start_flag  output  1  one-cycle pulse to board_updater.
- turn  output  1  1 = black to move, 0 = white to move.
- cursor_row  output  4  current cursor row, for the display.
- cursor_col  output  4  current cursor column, for the display.
- busy  output  1  high whenever state != IDLE.
- illegal_pulse  output  1  one cycle: confirm was pressed on an occupied point.
- pass_pulse  output  1  one cycle: a pass was accepted.
- timeout_pulse  output  1  one cycle: board_ready never arrived.

Behaviour:
- Reset values: cursor_row = cursor_col = RESET_POS; move_out = 0; turn = 1; all pulse outputs = 0; busy = 0; state = IDLE.
- On reset each button edge register loads the current button level, so a button held through reset produces no edge.
- Edge detection: an action occurs only on a rising edge (level = 1 and previous = 0). One edge is one action; holding a button never auto-repeats.
- Cursor updates apply only in IDLE; edges arriving in any other state are dropped.
- Row wraps: up at 0 goes to 8, down at 8 goes to 0. Columns wrap the same way with left/right.
- If up and down edge in the same cycle, the row is unchanged. Left and right together likewise leave the column unchanged.
- A cursor update lands the cycle after the edge.
- FSM states: IDLE, CHECK, ISSUE, WAIT.
- IDLE, confirm edge: latch {cursor_row, cursor_col} into the move register and go to CHECK.
- IDLE, pass edge (no confirm edge that cycle): toggle turn, pulse pass_pulse, stay in IDLE.
- IDLE, confirm and pass in the same cycle: confirm wins and the pass is dropped. Cursor edges in that same cycle still apply, but the move latches the pre-update cursor.
- CHECK (1 cycle): read board at the latched row/col.
  - 00: go to ISSUE.
  - Anything else: pulse illegal_pulse and return to IDLE; turn unchanged.
- ISSUE (1 cycle): drive move_out with the latched move and start_flag = 1, then go to WAIT.
- move_out changes only in ISSUE and holds until the next ISSUE, so latency from confirm edge to start_flag is 2 cycles.
- WAIT: clear the timeout counter on entry.
  - Rising edge of board_ready: toggle turn and go to IDLE. A level left high from an earlier update is ignored.
  - Counter reaches TIMEOUT_CYCLES - 1 with no edge: pulse timeout_pulse, go to IDLE, turn unchanged.
  - If the timeout and a board_ready edge land in the same cycle, board_ready wins.
- Reset mid-operation (any state) returns to IDLE with reset values. A start_flag already emitted is not retracted.
- Width rules: the timeout counter is $clog2(TIMEOUT_CYCLES) bits. Cursor arithmetic is 4-bit with explicit compare-and-wrap; no modulo operator.

Decomposition:
- Package go_pkg:
  - cell_t enum (EMPTY = 2'b00, BLACK = 2'b01, WHITE = 2'b10).
  - BOARD_N.
  - move_t packed struct {logic [3:0] row; logic [3:0] col;}.
  - board_t typedef for the 9x9 array.
  - Shared by board_updater, display and game_fsm.
- Sub-module: wrap_counter9, instantiated twice (row and column).
  - Inputs: inc, dec, en. Output: 4-bit value.
  - Reset loads RESET_POS.
  - Owns the wrap logic and the simultaneous inc/dec rule.

Test Plan:
- Reset, then 5 btn_up edges -> cursor_row sequence 3, 2, 1, 0, 8; cursor_col stays 4.
- Right and left edges in the same cycle from col 4 -> cursor_col stays 4. A single right edge at col 8 -> cursor_col = 0.
- Empty board, cursor at (4,1), confirm edge at cycle t -> start_flag high only at t+2 with move_out = 8'h41. board_ready rising at t+10 -> turn goes 1->0 at t+11 and busy drops.
- board[4][6] = BLACK, cursor (4,6), confirm -> illegal_pulse for one cycle, no start_flag, turn and move_out unchanged.
- Confirm on an empty point with board_ready held low and TIMEOUT_CYCLES overridden to 16 -> timeout_pulse after 16 WAIT cycles; turn unchanged; next confirm is accepted.
- Pass edge in IDLE -> pass_pulse and turn toggles. Pass and confirm in the same cycle -> only the move is issued. rst_in asserted during WAIT -> turn = 1, cursor = (4,4), busy = 0 next cycle.
